pulse_gate_gen: RTL and testbench

- Inverse of the edge-capture primitive: converts a single-cycle trigger pulse back into a level gate.
- After a trigger, waits a programmable delay, then drives a valid level for a programmable number of cycles.
- Used to regenerate line/frame valid windows and sensor integration gates from event pulses in the image pipeline.
- Reports busy state and emits start and done pulses so downstream logic can chain on it.

---
 rtl/pulse_gate_gen.sv | 126 ++++++++++++
 tb/tb_pulse_gate_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pulse_gate_gen.sv
// Trigger-to-gate generator: after an accepted trigger it waits a latched delay,
// then drives a valid level for a latched number of cycles, with start/done/busy status.
module pulse_gate_gen #(
  parameter int    CNT_WIDTH = 16,
  parameter string RETRIGGER = "ignore",
  parameter string POLARITY  = "high"
) (
  input  logic                 i_Sys_clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Trig,
  input  logic [CNT_WIDTH-1:0] i_Delay,
  input  logic [CNT_WIDTH-1:0] i_Width,
  input  logic                 i_Abort,
  output logic                 o_Dout_valid,
  output logic                 o_Busy,
  output logic                 o_Start,
  output logic                 o_Done
);

  localparam bit                   RESTART_C = (RETRIGGER == "restart");
  localparam bit                   INVERT_C  = (POLARITY == "low");
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO_C = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE_C  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t               state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] width_r;
  logic                 valid_r;
  logic                 busy_r;
  logic                 start_r;
  logic                 done_r;
  logic                 accept_s;

  // Map the internal active/inactive gate level onto the output pin polarity.
  function automatic logic pin_level(input logic active);
    return active ^ INVERT_C;
  endfunction

  // Trigger acceptance: abort always wins; a busy block only takes triggers in restart mode.
  always_comb begin
    accept_s = 1'b0;
    if (i_Trig && !i_Abort && (i_Width != CNT_ZERO_C)) begin
      if (state_r == IDLE) begin
        accept_s = 1'b1;
      end else begin
        accept_s = RESTART_C;
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  // Sequencer: state, down-counter and all registered outputs.
  always_ff @(posedge i_Sys_clk) begin
    if (!i_Rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO_C;
      width_r <= CNT_ZERO_C;
      valid_r <= pin_level(1'b0);
      busy_r  <= 1'b0;
      start_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      start_r <= 1'b0;
      done_r  <= 1'b0;
      if (i_Abort && (state_r != IDLE)) begin
        state_r <= IDLE;
        cnt_r   <= CNT_ZERO_C;
        valid_r <= pin_level(1'b0);
        busy_r  <= 1'b0;
      end else if (accept_s) begin
        width_r <= i_Width;
        busy_r  <= 1'b1;
        if (i_Delay == CNT_ZERO_C) begin
          state_r <= ACTIVE;
          cnt_r   <= i_Width;
          valid_r <= pin_level(1'b1);
          start_r <= 1'b1;
        end else begin
          state_r <= DELAY;
          cnt_r   <= i_Delay;
          valid_r <= pin_level(1'b0);
        end
      end else begin
        case (state_r)
          DELAY: begin
            if (cnt_r == CNT_ONE_C) begin
              state_r <= ACTIVE;
              cnt_r   <= width_r;
              valid_r <= pin_level(1'b1);
              start_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r - CNT_ONE_C;
            end
          end
          ACTIVE: begin
            if (cnt_r == CNT_ONE_C) begin
              state_r <= IDLE;
              cnt_r   <= CNT_ZERO_C;
              valid_r <= pin_level(1'b0);
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              cnt_r <= cnt_r - CNT_ONE_C;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_Dout_valid = valid_r;
  assign o_Busy       = busy_r;
  assign o_Start      = start_r;
  assign o_Done       = done_r;

endmodule

// File: tb/tb_pulse_gate_gen.sv
// Scoreboard bench for pulse_gate_gen: four instances (ignore, restart, low polarity, 4-bit)
// with hand-computed per-cycle expectations queued ahead of the stimulus.
module tb_pulse_gate_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  trig = 4'b0000;
  logic [15:0] delay = 16'd0;
  logic [15:0] width = 16'd0;
  logic        abort = 1'b0;
  logic        dv [4];
  logic        busy [4];
  logic        start [4];
  logic        done [4];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    int       cyc;
    int       inst;
    logic [3:0] exp;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_gate_gen #(.CNT_WIDTH(16), .RETRIGGER("ignore"), .POLARITY("high")) u_ign (
    .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_Trig(trig[0]), .i_Delay(delay), .i_Width(width),
    .i_Abort(abort), .o_Dout_valid(dv[0]), .o_Busy(busy[0]), .o_Start(start[0]), .o_Done(done[0]));
  pulse_gate_gen #(.CNT_WIDTH(16), .RETRIGGER("restart"), .POLARITY("high")) u_rst (
    .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_Trig(trig[1]), .i_Delay(delay), .i_Width(width),
    .i_Abort(abort), .o_Dout_valid(dv[1]), .o_Busy(busy[1]), .o_Start(start[1]), .o_Done(done[1]));
  pulse_gate_gen #(.CNT_WIDTH(16), .RETRIGGER("ignore"), .POLARITY("low")) u_low (
    .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_Trig(trig[2]), .i_Delay(delay), .i_Width(width),
    .i_Abort(abort), .o_Dout_valid(dv[2]), .o_Busy(busy[2]), .o_Start(start[2]), .o_Done(done[2]));
  pulse_gate_gen #(.CNT_WIDTH(4), .RETRIGGER("ignore"), .POLARITY("high")) u_w4 (
    .i_Sys_clk(clk), .i_Rst_n(rst_n), .i_Trig(trig[3]), .i_Delay(delay[3:0]), .i_Width(width[3:0]),
    .i_Abort(abort), .o_Dout_valid(dv[3]), .o_Busy(busy[3]), .o_Start(start[3]), .o_Done(done[3]));

  // Queue expected {valid_pin, busy, start, done} for cycles c0..c1 of one instance.
  task automatic push_win(input int inst, input int c0, input int c1, input int v0, input int v1,
                          input int b0, input int b1, input int st1, input int st2, input int dn,
                          input bit low);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc  = c;
      e.inst = inst;
      e.exp  = {((c >= v0) && (c <= v1)) ^ low, (c >= b0) && (c <= b1),
                (c == st1) || (c == st2), c == dn};
      q.push_back(e);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int t, input logic [3:0] m);
    goto(t);
    trig = m;
    @(posedge clk);
    #1;
    trig = 4'b0000;
  endtask

  // Monitor: every cycle, pop all entries due now and compare against the addressed instance.
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        logic [3:0] act;
        act = {dv[q[i].inst], busy[q[i].inst], start[q[i].inst], done[q[i].inst]};
        n_cmp = n_cmp + 1;
        if (q[i].cyc < cyc) begin
          n_bad = n_bad + 1;
          $display("FAIL stale inst%0d cyc%0d: entry not checked in time, now cyc%0d", q[i].inst, q[i].cyc, cyc);
        end else if (act !== q[i].exp) begin
          n_bad = n_bad + 1;
          $display("FAIL gate inst%0d cyc%0d: v/b/s/d got %b required %b", q[i].inst, cyc, act, q[i].exp);
        end
        q.delete(i);
      end
    end
  end

  initial begin
    // Reset state on all instances; low-polarity pin idles high.
    for (int k = 0; k < 4; k++) push_win(k, 1, 6, 1, 0, 1, 0, -1, -1, -1, k == 2);
    goto(3);
    rst_n = 1'b1;

    // Basic D=3 W=5 trigger at 110 on the ignore and low-polarity instances.
    push_win(0, 105, 125, 114, 118, 111, 118, 114, -1, 119, 1'b0);
    push_win(2, 105, 125, 114, 118, 111, 118, 114, -1, 119, 1'b1);
    goto(108);
    delay = 16'd3;
    width = 16'd5;
    pulse(110, 4'b0101);

    // D=0 W=1 at 205; then D=4 W=0 at 215 is discarded.
    push_win(0, 201, 212, 206, 206, 206, 206, 206, -1, 207, 1'b0);
    push_win(0, 213, 225, 1, 0, 1, 0, -1, -1, -1, 1'b0);
    goto(203);
    delay = 16'd0;
    width = 16'd1;
    pulse(205, 4'b0001);
    delay = 16'd4;
    width = 16'd0;
    pulse(215, 4'b0001);

    // Retrigger D=2 W=10 at 310 and 314: ignore keeps one gate, restart relaunches.
    push_win(0, 305, 335, 313, 322, 311, 322, 313, -1, 323, 1'b0);
    push_win(1, 305, 312, 1, 0, 311, 312, -1, -1, -1, 1'b0);
    push_win(1, 313, 314, 313, 314, 313, 314, 313, -1, -1, 1'b0);
    push_win(1, 315, 335, 317, 326, 315, 326, 317, -1, 327, 1'b0);
    goto(308);
    delay = 16'd2;
    width = 16'd10;
    pulse(310, 4'b0011);
    pulse(314, 4'b0011);

    // Abort during ACTIVE; then abort together with trigger in IDLE.
    push_win(0, 401, 415, 404, 406, 403, 406, 404, -1, -1, 1'b0);
    push_win(0, 416, 425, 1, 0, 1, 0, -1, -1, -1, 1'b0);
    goto(400);
    delay = 16'd1;
    width = 16'd8;
    pulse(402, 4'b0001);
    goto(406);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    delay = 16'd0;
    width = 16'd3;
    goto(418);
    abort = 1'b1;
    trig = 4'b0001;
    @(posedge clk);
    #1;
    abort = 1'b0;
    trig = 4'b0000;

    // 4-bit counters at maximum D=W=15, then a trigger in the done cycle.
    push_win(3, 500, 533, 518, 532, 503, 532, 518, -1, 533, 1'b0);
    push_win(3, 534, 540, 534, 535, 534, 535, 534, -1, 536, 1'b0);
    goto(500);
    delay = 16'd15;
    width = 16'd15;
    pulse(502, 4'b1000);
    delay = 16'd0;
    width = 16'd2;
    pulse(533, 4'b1000);

    // Reset asserted during DELAY on the low-polarity instance.
    push_win(2, 601, 615, 1, 0, 603, 605, -1, -1, -1, 1'b1);
    goto(600);
    delay = 16'd5;
    width = 16'd3;
    pulse(602, 4'b0100);
    goto(605);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
